// File: rtl/rf_pkg.sv
// Shared register-file package.
// Holds the register-file geometry constants and the requester id used by the
// write-back arbiter's round-robin pointer.
package rf_pkg;

  localparam int           RF_ADDR_W = 5;
  localparam int           RF_DATA_W = 32;
  localparam int           RF_DEPTH  = 32;
  localparam logic [4:0]   RF_ZERO   = 5'd0;

  // Requester identity; also the encoding of the round-robin priority pointer.
  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle for the register-file write-back arbiter.
// Two producers, A (ALU result) and B (load unit), each with a valid/ready
// handshake carrying a destination address and write data.
//   master : producer side (drives valid/addr/data, receives ready)
//   slave  : arbiter side  (receives valid/addr/data, drives ready)
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard used for RAW hazard stalls.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   set_en, set_addr   : mark a destination register as pending
//   clr_en, clr_addr   : a write to that register has completed
//   busy               : one bit per register; bit 0 is always 0
// When set and clear hit the same register in one cycle the set wins, because
// the set belongs to a newer producer that is still outstanding.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [ADDR_W-1:0]         set_addr,
  input  logic                      clr_en,
  input  logic [ADDR_W-1:0]         clr_addr,
  output logic [(1<<ADDR_W)-1:0]    busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] busy_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    // Clear first, then set: the newer allocation survives a same-cycle clear.
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its inputs from before the edge, independent of block order.
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard for the register file.
// Shares the file's single write port between the ALU (A) and the load unit
// (B) with a round-robin grant, registers the write port outputs, and keeps
// the busy scoreboard for issue-stage hazard checks.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   bus (slave)              : A/B valid/ready/addr/data write-back requests
//   alloc_valid, alloc_addr  : issue stage marks a destination as pending
//   busy                     : scoreboard, one bit per register
//   Write_Reg, Addr, Data    : registered write port to the register file
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_arbiter_if.slave    bus,
  input  logic                   alloc_valid,
  input  logic [ADDR_W-1:0]      alloc_addr,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   Write_Reg,
  output logic [ADDR_W-1:0]      Addr,
  output logic [DATA_W-1:0]      Data
);

  req_e              prio;
  req_e              prio_next;
  logic              grant_a;
  logic              grant_b;
  logic              grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Grant logic. Gated by rst so that no request is acknowledged while the
  // block is held in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      if (bus.a_valid && (!bus.b_valid || prio == REQ_ALU)) grant_a = 1'b1;
      else if (bus.b_valid)                                 grant_b = 1'b1;
    end
    grant    = grant_a | grant_b;
    win_addr = grant_b ? bus.b_addr : bus.a_addr;
    win_data = grant_b ? bus.b_data : bus.a_data;

    // The pointer moves away from whoever just won, bounding the loser's wait
    // to a single transfer.
    prio_next = prio;
    if (grant_a)      prio_next = REQ_LOAD;
    else if (grant_b) prio_next = REQ_ALU;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio      <= REQ_ALU;
      Write_Reg <= 1'b0;
      Addr      <= '0;
      Data      <= '0;
    end else begin
      prio      <= prio_next;
      // Address 0 is hardwired: the request is still accepted, just not written.
      Write_Reg <= grant && (win_addr != ADDR_W'(RF_ZERO));
      if (grant) begin
        Addr <= win_addr;
        Data <= win_data;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (alloc_valid && (alloc_addr != ADDR_W'(RF_ZERO))),
    .set_addr (alloc_addr),
    .clr_en   (grant),
    .clr_addr (win_addr),
    .busy     (busy)
  );

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It shares the file's single write port between two producers: port A (ALU result) and port B (load unit). Arbitration is round-robin with valid/ready handshakes. The block drives the file's `Write_Reg`/`Addr`/`Data` inputs from registers, and it keeps a per-register busy scoreboard that issue logic uses for RAW hazard stalls.

## Interface
- `DATA_W`, default 32, width of write data.
- `ADDR_W`, default 5, register address width. The file depth is 2^ADDR_W.
- `clk` in 1: single clock. All state updates on the rising edge. The register file samples on the falling edge.
- `rst` in 1: reset, asynchronous and active-low.
- `a_valid` in 1: ALU write-back request.
- `a_ready` out 1: ALU request accepted this cycle.
- `a_addr` in ADDR_W: ALU destination register.
- `a_data` in DATA_W: ALU result.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as the `a_*` ports, for the load unit.
- `alloc_valid` in 1: issue stage marks a destination register as pending.
- `alloc_addr` in ADDR_W: register being allocated.
- `busy` out 2^ADDR_W: scoreboard, one bit per register. Bit 0 is always 0.
- `Write_Reg` out 1: write enable to the register file.
- `Addr` out ADDR_W: write address to the register file.
- `Data` out DATA_W: write data to the register file.

## Operation
- **Handshake.** A transfer occurs when `x_valid && x_ready` at a rising edge.
  - A producer holds valid, addr and data stable until it is accepted.
  - `x_ready` may depend combinationally on the valids. Valid must never depend on ready.
- **Grant rule.**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the priority pointer `prio` (0 = A, 1 = B) is granted.
  - `ready` is asserted only for the granted requester.
- **Pointer update.** After any grant, `prio` points to the other requester. With no grant, `prio` is unchanged. This bounds the wait to one transfer.
- **Output register.**
  - On a grant, `Write_Reg`, `Addr` and `Data` load from the winner at the same rising edge.
  - With no grant, `Write_Reg` goes to 0. `Addr` and `Data` hold their values.
- **Address 0.** A request to address 0 is accepted normally (ready asserted, pointer advances), but `Write_Reg` stays 0.
- **Scoreboard.**
  - `alloc_valid` with `alloc_addr` ≠ 0 sets that `busy` bit at the rising edge.
  - A granted write to address n clears `busy[n]` at the same edge.
  - Simultaneous alloc and clear of the same address: the set wins, because a newer producer is pending.
  - Alloc to address 0 is ignored.
- **Same-address requests.** A and B both targeting address n are serialised in grant order, and the last granted write persists.
- No internal queuing. A requester that is not granted simply keeps its valid high.

## Timing
- **Reset values.** `Write_Reg`=0, `Addr`=0, `Data`=0, `busy`=0, `prio`=0 (A first). `a_ready`/`b_ready` follow the grant logic, so they are 0 while `rst` is low.
- **Reset mid-operation.** Assertion clears all state immediately. Any request whose handshake had not completed before assertion is lost. Release is synchronised by the system.
- **Write latency.**
  - Handshake at rising edge N puts the write on the port during cycle N.
  - The register file captures it at the falling edge within that cycle.
  - A read of the destination is valid from the second half of cycle N.
- **Scoreboard latency.** `busy` changes are visible the cycle after the edge that caused them.
- **Throughput.** One write per cycle. Under continuous contention A and B alternate exactly.

## Structure
- Shared package `rf_pkg`:
  - constants `RF_ADDR_W`=5, `RF_DATA_W`=32, `RF_DEPTH`=32, `RF_ZERO`=5'd0;
  - requester-id enum `{REQ_ALU, REQ_LOAD}` used for `prio`.
- Sub-module `rf_scoreboard`, holding the busy-bit array with set/clear priority, kept separate so the issue stage can reuse it.
- Arbitration and the output register live in the top module.

## Test plan
- **Reset.** Drop `rst` low mid-cycle with `busy`=32'h0000_0006 → all outputs and `busy` read 0 asynchronously, and `prio`=A after release.
- **Single requester.** A only, addr 5, data 32'hDEAD_BEEF → `a_ready`=1; next cycle `Write_Reg`=1, `Addr`=5, `Data`=DEAD_BEEF; the file reads DEAD_BEEF at address 5 after the falling edge.
- **Contention.** A and B both valid for 4 cycles (A addr 3, B addr 4) → grants go A, B, A, B, and `Write_Reg` stays high every cycle.
- **Address 0.** B writes addr 0, data 32'h1234 → `b_ready`=1, `Write_Reg` stays 0, and register 0 still reads 0.
- **Scoreboard.** Alloc addr 7, then alloc 7 again in the same cycle as an A write to 7 → `busy[7]`=1 after both events; a following write to 7 with no alloc → `busy[7]`=0.
- **Same address.** A and B both write addr 9 (A=32'h1, B=32'h2) with `prio`=B → final value at register 9 is 32'h1.
